// File: rtl/frame_stream_assembler_pkg.sv
// Shared sizing, bus word and stream entry types for the frame stream assembler.
package frame_stream_assembler_pkg;
  localparam int PIXEL_ARRAY_WIDTH  = 8;
  localparam int PIXEL_ARRAY_HEIGHT = 4;
  localparam int OUTPUT_BUS_WIDTH   = 2;
  localparam int PIXEL_BITS         = 10;
  localparam int WORD_BITS          = OUTPUT_BUS_WIDTH * PIXEL_BITS;
  localparam int WORDS_PER_ROW      = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH;

  typedef logic [WORD_BITS-1:0] bus_word_t;

  typedef struct packed {
    logic      sof;
    logic      eof;
    logic      sor;
    logic      eor;
    bus_word_t data;
  } stream_entry_t;

  // Modulo-2^16 sum of every pixel slice in a bus word.
  function automatic logic [15:0] word_pixel_sum(input bus_word_t w);
    logic [15:0] s;
    s = '0;
    for (int i = 0; i < OUTPUT_BUS_WIDTH; i++)
      s = s + 16'(w[i*PIXEL_BITS +: PIXEL_BITS]);
    return s;
  endfunction
endpackage

// File: rtl/frame_stream_assembler_stream_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is accepted only when
// a pop happens in the same cycle, otherwise it is dropped and DROP pulses.
module stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             WR_EN,
  input  logic [WIDTH-1:0] WR_DATA,
  input  logic             RD_EN,
  output logic [WIDTH-1:0] RD_DATA,
  output logic             EMPTY,
  output logic             DROP
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             full, push, pop;

  assign EMPTY = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign pop   = RD_EN & ~EMPTY;
  assign push  = WR_EN & (~full | pop);
  assign DROP  = WR_EN & full & ~pop;
  // Head reads as zero while empty so outputs are clean after reset.
  assign RD_DATA = EMPTY ? '0 : mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= WR_DATA;
  end
endmodule

// File: rtl/frame_stream_assembler.sv
// Tags output-buffer bus words with frame/row markers and queues them for readout.
// Optional FRAME_SUM output enabled by FRAME_STREAM_ASSEMBLER_FRAME_SUM_EN.
module frame_stream_assembler
  import frame_stream_assembler_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int ROWS       = PIXEL_ARRAY_HEIGHT
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 FRAME_START,
  input  logic                 BUS_VALID,
  input  logic [WORD_BITS-1:0] BUS_DATA,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [WORD_BITS-1:0] OUT_DATA,
  output logic                 OUT_SOF,
  output logic                 OUT_EOF,
  output logic                 OUT_SOR,
  output logic                 OUT_EOR,
  output logic                 OVERFLOW,
  output logic                 ALIGN_ERR,
`ifdef FRAME_STREAM_ASSEMBLER_FRAME_SUM_EN
  output logic [15:0]          FRAME_SUM,
`endif
  input  logic                 ERR_CLEAR
);
  localparam int WCW = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
  localparam int RCW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [WCW-1:0] WC_LAST = WCW'(WORDS_PER_ROW - 1);
  localparam logic [RCW-1:0] RC_LAST = RCW'(ROWS - 1);

  logic [WCW-1:0] word_cnt, wc_eff, wc_nxt;
  logic [RCW-1:0] row_cnt, rc_eff, rc_nxt;
  logic           bv_q, misalign, drop, empty;
  stream_entry_t  entry, head;

  always_comb begin
    wc_eff     = FRAME_START ? '0 : word_cnt;
    rc_eff     = FRAME_START ? '0 : row_cnt;
    entry.data = BUS_DATA;
    entry.sor  = (wc_eff == '0);
    entry.eor  = (wc_eff == WC_LAST);
    entry.sof  = entry.sor & (rc_eff == '0);
    entry.eof  = entry.eor & (rc_eff == RC_LAST);
    misalign   = bv_q & ~BUS_VALID & (word_cnt != '0);
    wc_nxt     = wc_eff;
    rc_nxt     = rc_eff;
    if (BUS_VALID) begin
      if (entry.eor) begin
        wc_nxt = '0;
        rc_nxt = (rc_eff == RC_LAST) ? '0 : rc_eff + 1'b1;
      end else begin
        wc_nxt = wc_eff + 1'b1;
      end
    end else if (misalign && !FRAME_START) begin
      // A truncated row still consumes a row slot.
      wc_nxt = '0;
      rc_nxt = (row_cnt == RC_LAST) ? '0 : row_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      word_cnt  <= '0;
      row_cnt   <= '0;
      bv_q      <= 1'b0;
      OVERFLOW  <= 1'b0;
      ALIGN_ERR <= 1'b0;
    end else begin
      word_cnt  <= wc_nxt;
      row_cnt   <= rc_nxt;
      bv_q      <= BUS_VALID;
      OVERFLOW  <= drop | (OVERFLOW & ~ERR_CLEAR);
      ALIGN_ERR <= misalign | (ALIGN_ERR & ~ERR_CLEAR);
    end
  end

  stream_fifo #(.WIDTH($bits(stream_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK     (CLK),
    .RESET   (RESET),
    .WR_EN   (BUS_VALID),
    .WR_DATA (entry),
    .RD_EN   (OUT_READY),
    .RD_DATA (head),
    .EMPTY   (empty),
    .DROP    (drop)
  );

  assign OUT_VALID = ~empty;
  assign OUT_DATA  = head.data;
  assign OUT_SOF   = head.sof;
  assign OUT_EOF   = head.eof;
  assign OUT_SOR   = head.sor;
  assign OUT_EOR   = head.eor;

`ifdef FRAME_STREAM_ASSEMBLER_FRAME_SUM_EN
  // Dropped words still count toward the sum: accumulate on capture, not on push.
  logic [15:0] acc, acc_nxt;
  assign acc_nxt = (entry.sof ? 16'd0 : acc) + word_pixel_sum(BUS_DATA);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      acc       <= '0;
      FRAME_SUM <= '0;
    end else if (BUS_VALID) begin
      acc <= acc_nxt;
      if (entry.eof) FRAME_SUM <= acc_nxt;
    end
  end
`endif
endmodule

// File: tb/tb_frame_stream_assembler.sv
// Directed bench for frame_stream_assembler: tagging, overflow, alignment, reset.
module tb_frame_stream_assembler;
  import frame_stream_assembler_pkg::*;

  logic            CLK = 1'b0;
  logic            RESET, FRAME_START, BUS_VALID, OUT_READY, ERR_CLEAR;
  logic [WORD_BITS-1:0] BUS_DATA, OUT_DATA;
  logic            OUT_VALID, OUT_SOF, OUT_EOF, OUT_SOR, OUT_EOR, OVERFLOW, ALIGN_ERR;
`ifdef FRAME_STREAM_ASSEMBLER_FRAME_SUM_EN
  logic [15:0]     FRAME_SUM;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [23:0] rx[$];
  logic [23:0] exp_q[$];

  always #5 CLK = ~CLK;

  frame_stream_assembler #(.FIFO_DEPTH(8), .ROWS(4)) dut (
    .CLK(CLK), .RESET(RESET), .FRAME_START(FRAME_START),
    .BUS_VALID(BUS_VALID), .BUS_DATA(BUS_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .OUT_SOF(OUT_SOF), .OUT_EOF(OUT_EOF), .OUT_SOR(OUT_SOR), .OUT_EOR(OUT_EOR),
    .OVERFLOW(OVERFLOW), .ALIGN_ERR(ALIGN_ERR),
`ifdef FRAME_STREAM_ASSEMBLER_FRAME_SUM_EN
    .FRAME_SUM(FRAME_SUM),
`endif
    .ERR_CLEAR(ERR_CLEAR)
  );

  // Inputs change 1 time unit after posedge, so at negedge they describe the coming edge.
  always @(negedge CLK)
    if (RESET && OUT_VALID && OUT_READY)
      rx.push_back({OUT_SOF, OUT_EOF, OUT_SOR, OUT_EOR, OUT_DATA});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drv(input logic bv, input logic [WORD_BITS-1:0] d, input logic fs,
                     input logic rdy, input logic clr);
    BUS_VALID = bv; BUS_DATA = d; FRAME_START = fs; OUT_READY = rdy; ERR_CLEAR = clr;
  endtask

  task automatic cyc(input logic bv, input logic [WORD_BITS-1:0] d, input logic fs,
                     input logic rdy, input logic clr);
    tick();
    drv(bv, d, fs, rdy, clr);
  endtask

  // f = {sof, eof, sor, eor}
  task automatic ex(input logic [3:0] f, input logic [WORD_BITS-1:0] d);
    exp_q.push_back({f, d});
  endtask

  task automatic cmp_rx(input string tag);
    int n;
    chk({tag, "_count"}, rx.size(), exp_q.size());
    n = (rx.size() < exp_q.size()) ? rx.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_w%0d", tag, i), rx[i], exp_q[i]);
    rx.delete();
    exp_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b0;
    drv(0, '0, 0, 0, 0);
    tick(); tick();
    chk("rst_valid", OUT_VALID, 0);
    chk("rst_data", OUT_DATA, 0);
    chk("rst_marks", {OUT_SOF, OUT_EOF, OUT_SOR, OUT_EOR}, 0);
    chk("rst_flags", {OVERFLOW, ALIGN_ERR}, 0);
`ifdef FRAME_STREAM_ASSEMBLER_FRAME_SUM_EN
    chk("rst_sum", FRAME_SUM, 0);
`endif
    RESET = 1'b1;

    // Contiguous frame, consumer always ready.
    for (int i = 1; i <= 16; i++) cyc(1, WORD_BITS'(i), i == 1, 1, 0);
    repeat (3) cyc(0, '0, 0, 1, 0);
    ex(4'b1010, 'h1); ex(0, 'h2); ex(0, 'h3); ex(4'b0001, 'h4);
    ex(4'b0010, 'h5); ex(0, 'h6); ex(0, 'h7); ex(4'b0001, 'h8);
    ex(4'b0010, 'h9); ex(0, 'ha); ex(0, 'hb); ex(4'b0001, 'hc);
    ex(4'b0010, 'hd); ex(0, 'he); ex(0, 'hf); ex(4'b0101, 'h10);
    cmp_rx("frame");
    chk("frame_flags", {OVERFLOW, ALIGN_ERR}, 0);
`ifdef FRAME_STREAM_ASSEMBLER_FRAME_SUM_EN
    chk("frame_sum", FRAME_SUM, 16'h0088);
`endif

    // Nine words into a stalled 8-deep FIFO, then full push+pop.
    cyc(1, 'h101, 1, 0, 0);
    for (int i = 2; i <= 9; i++) cyc(1, WORD_BITS'('h100 + i), 0, 0, 0);
    tick();
    chk("ovf_set", OVERFLOW, 1);
    chk("ovf_valid", OUT_VALID, 1);
    chk("ovf_head", {OUT_SOF, OUT_EOF, OUT_SOR, OUT_EOR, OUT_DATA}, {4'b1010, 20'h101});
    drv(1, 'h10a, 0, 1, 1);
    cyc(1, 'h10b, 0, 1, 0);
    cyc(1, 'h10c, 0, 1, 0);
    tick();
    chk("full_pushpop_ovf", OVERFLOW, 0);
    chk("full_pushpop_valid", OUT_VALID, 1);
    drv(0, '0, 0, 1, 0);
    repeat (10) cyc(0, '0, 0, 1, 0);
    ex(4'b1010, 'h101); ex(0, 'h102); ex(0, 'h103); ex(4'b0001, 'h104);
    ex(4'b0010, 'h105); ex(0, 'h106); ex(0, 'h107); ex(4'b0001, 'h108);
    ex(0, 'h10a); ex(0, 'h10b); ex(4'b0001, 'h10c);
    cmp_rx("ovf");
    chk("ovf_align", ALIGN_ERR, 0);

    // Truncated row: two words then BUS_VALID drops.
    cyc(1, 'h201, 1, 1, 0);
    cyc(1, 'h202, 0, 1, 0);
    cyc(0, '0, 0, 1, 0);
    tick();
    chk("align_set", ALIGN_ERR, 1);
    drv(1, 'h203, 0, 1, 0);
    cyc(1, 'h204, 0, 1, 0);
    cyc(1, 'h205, 0, 1, 0);
    cyc(1, 'h206, 0, 1, 0);
    cyc(0, '0, 0, 1, 1);
    cyc(0, '0, 0, 1, 0);
    chk("align_clear", ALIGN_ERR, 0);
    repeat (3) cyc(0, '0, 0, 1, 0);
    ex(4'b1010, 'h201); ex(0, 'h202); ex(4'b0010, 'h203);
    ex(0, 'h204); ex(0, 'h205); ex(4'b0001, 'h206);
    cmp_rx("align");
    chk("align_ovf", OVERFLOW, 0);

    // FRAME_START arrives mid-frame on the second word of row 2.
    cyc(1, 'h301, 1, 1, 0);
    for (int i = 2; i <= 13; i++) cyc(1, WORD_BITS'('h300 + i), i == 10, 1, 0);
    repeat (3) cyc(0, '0, 0, 1, 0);
    ex(4'b1010, 'h301); ex(0, 'h302); ex(0, 'h303); ex(4'b0001, 'h304);
    ex(4'b0010, 'h305); ex(0, 'h306); ex(0, 'h307); ex(4'b0001, 'h308);
    ex(4'b0010, 'h309); ex(4'b1010, 'h30a); ex(0, 'h30b); ex(0, 'h30c);
    ex(4'b0001, 'h30d);
    cmp_rx("fs_mid");
    chk("fs_mid_align", ALIGN_ERR, 0);

    // Reset with five words queued and ALIGN_ERR set.
    cyc(1, 'h401, 1, 0, 0);
    for (int i = 2; i <= 5; i++) cyc(1, WORD_BITS'('h400 + i), 0, 0, 0);
    cyc(0, '0, 0, 0, 0);
    tick();
    chk("pre_rst_align", ALIGN_ERR, 1);
    chk("pre_rst_valid", OUT_VALID, 1);
    RESET = 1'b0;
    tick();
    chk("mid_rst_valid", OUT_VALID, 0);
    chk("mid_rst_data", OUT_DATA, 0);
    chk("mid_rst_flags", {OVERFLOW, ALIGN_ERR}, 0);
`ifdef FRAME_STREAM_ASSEMBLER_FRAME_SUM_EN
    chk("mid_rst_sum", FRAME_SUM, 0);
`endif
    RESET = 1'b1;
    drv(1, 'h501, 0, 1, 0);
    cyc(1, 'h502, 0, 1, 0);
    cyc(1, 'h503, 0, 1, 0);
    cyc(1, 'h504, 0, 1, 0);
    repeat (3) cyc(0, '0, 0, 1, 0);
    ex(4'b1010, 'h501); ex(0, 'h502); ex(0, 'h503); ex(4'b0001, 'h504);
    cmp_rx("post_rst");

`ifdef FRAME_STREAM_ASSEMBLER_FRAME_SUM_EN
    // 16 words x 2 pixels of 0x3FF: 32*1023 = 0x7FE0.
    for (int i = 1; i <= 16; i++) cyc(1, 20'hfffff, i == 1, 1, 0);
    repeat (3) cyc(0, '0, 0, 1, 0);
    chk("sum_full", FRAME_SUM, 16'h7fe0);
    chk("sum_words", rx.size(), 16);
    rx.delete();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
